stopwatch_bcd_counter: RTL and testbench

Stopwatch time base that consumes the gated one-cycle seconds tick produced by the start/pause control FSM. Counts elapsed time as four BCD digits, MM:SS, from 00:00 to 99:59. Drives the display digit bus toward the 7-segment multiplexer. Provides sticky overflow, a minute-carry strobe and an optional lap (split-time) freeze.

---
 rtl/stopwatch_bcd_counter.sv | 161 ++++++++++++++++
 tb/tb_stopwatch_bcd_counter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_bcd_counter.sv
// Purpose: MM:SS BCD stopwatch time base with sticky overflow, minute strobe and optional lap freeze (STOPWATCH_LAP_EN).
// Latency: one cycle from tick/clear/lap to every registered output; no combinational input-to-output paths.
// Backpressure: none; every tick cycle counts, clear has priority over tick and lap.
module stopwatch_bcd_counter #(
    parameter bit WRAP = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        clear,
    input  logic        lap,
    output logic [3:0]  sec_ones,
    output logic [3:0]  sec_tens,
    output logic [3:0]  min_ones,
    output logic [3:0]  min_tens,
    output logic [15:0] disp,
    output logic        min_pulse,
    output logic        ovf,
    output logic        lap_active
);

    typedef struct packed {
        logic [3:0] mt;
        logic [3:0] mo;
        logic [3:0] st;
        logic [3:0] so;
    } bcd_time_t;

    bcd_time_t time_q, time_d, time_inc;
    logic      min_pulse_q, min_pulse_d;
    logic      ovf_q, ovf_d;
    logic      at_max, sec_roll;

    assign at_max   = (time_q == 16'h9959);
    assign sec_roll = (time_q.so == 4'd9) && (time_q.st == 4'd5);

    // BCD ripple increment of the live time; 99:59 naturally rolls to 00:00.
    always_comb begin
        time_inc = time_q;
        if (time_q.so == 4'd9) begin
            time_inc.so = 4'd0;
            if (time_q.st == 4'd5) begin
                time_inc.st = 4'd0;
                if (time_q.mo == 4'd9) begin
                    time_inc.mo = 4'd0;
                    time_inc.mt = (time_q.mt == 4'd9) ? 4'd0 : time_q.mt + 4'd1;
                end else begin
                    time_inc.mo = time_q.mo + 4'd1;
                end
            end else begin
                time_inc.st = time_q.st + 4'd1;
            end
        end else begin
            time_inc.so = time_q.so + 4'd1;
        end
    end

    // Next live time and flags: clear wins, then tick with wrap/saturate at 99:59.
    always_comb begin
        time_d      = time_q;
        min_pulse_d = 1'b0;
        ovf_d       = ovf_q;
        if (clear) begin
            time_d = '0;
            ovf_d  = 1'b0;
        end else if (tick) begin
            if (at_max) begin
                ovf_d = 1'b1;
                if (WRAP) begin
                    time_d      = '0;
                    min_pulse_d = 1'b1;
                end
            end else begin
                time_d      = time_inc;
                min_pulse_d = sec_roll;
            end
        end
    end

    // Live time and flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            time_q      <= '0;
            min_pulse_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            time_q      <= time_d;
            min_pulse_q <= min_pulse_d;
            ovf_q       <= ovf_d;
        end
    end

    assign sec_ones  = time_q.so;
    assign sec_tens  = time_q.st;
    assign min_ones  = time_q.mo;
    assign min_tens  = time_q.mt;
    assign min_pulse = min_pulse_q;
    assign ovf       = ovf_q;

`ifdef STOPWATCH_LAP_EN
    typedef enum logic {
        LIVE   = 1'b0,
        FROZEN = 1'b1
    } lap_state_t;

    lap_state_t  state_q, state_d;
    logic [15:0] disp_q, disp_d;

    // Lap FSM state and display register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= LIVE;
            disp_q  <= '0;
        end else begin
            state_q <= state_d;
            disp_q  <= disp_d;
        end
    end

    // Lap toggling: entering FROZEN captures the pre-increment time, LIVE tracks the new time.
    always_comb begin
        state_d = state_q;
        disp_d  = disp_q;
        if (clear) begin
            state_d = LIVE;
            disp_d  = '0;
        end else begin
            case (state_q)
                LIVE: begin
                    if (lap) begin
                        state_d = FROZEN;
                        disp_d  = time_q;
                    end else begin
                        disp_d  = time_d;
                    end
                end
                FROZEN: begin
                    if (lap) begin
                        state_d = LIVE;
                        disp_d  = time_d;
                    end
                end
                default: begin
                    state_d = LIVE;
                    disp_d  = time_d;
                end
            endcase
        end
    end

    assign disp       = disp_q;
    assign lap_active = (state_q == FROZEN);
`else
    // Without lap support the display is simply the live time register.
    logic unused_lap;
    assign unused_lap = lap;
    assign disp       = time_q;
    assign lap_active = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Purpose: directed checks of stopwatch_bcd_counter, one wrapping and one saturating instance sharing stimulus.
// Latency: inputs driven at negedge, outputs sampled 1 ns after the following posedge.
// Backpressure: n/a; a global time limit guarantees termination.
module tb_stopwatch_bcd_counter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic tick = 1'b0;
    logic clear = 1'b0;
    logic lap = 1'b0;

    logic [3:0]  w_so, w_st, w_mo, w_mt, s_so, s_st, s_mo, s_mt;
    logic [15:0] w_disp, s_disp, w_time, s_time;
    logic        w_mp, w_ovf, w_la, s_mp, s_ovf, s_la;

    int checks = 0;
    int errors = 0;
    int pulses;

    assign w_time = {w_mt, w_mo, w_st, w_so};
    assign s_time = {s_mt, s_mo, s_st, s_so};

    always #5 clk = ~clk;

    stopwatch_bcd_counter #(.WRAP(1'b1)) u_wrap (
        .clk(clk), .rst(rst), .tick(tick), .clear(clear), .lap(lap),
        .sec_ones(w_so), .sec_tens(w_st), .min_ones(w_mo), .min_tens(w_mt),
        .disp(w_disp), .min_pulse(w_mp), .ovf(w_ovf), .lap_active(w_la)
    );

    stopwatch_bcd_counter #(.WRAP(1'b0)) u_sat (
        .clk(clk), .rst(rst), .tick(tick), .clear(clear), .lap(lap),
        .sec_ones(s_so), .sec_tens(s_st), .min_ones(s_mo), .min_tens(s_mt),
        .disp(s_disp), .min_pulse(s_mp), .ovf(s_ovf), .lap_active(s_la)
    );

    typedef struct {
        logic        t;
        logic        c;
        logic [15:0] exp_time;
        logic        exp_pulse;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle of stimulus, returning 1 ns after the sampling edge with inputs idle.
    task automatic step(input logic t, input logic c, input logic l);
        @(negedge clk);
        tick = t; clear = c; lap = l;
        @(posedge clk);
        #1;
        tick = 1'b0; clear = 1'b0; lap = 1'b0;
    endtask

    // Hold tick high for n consecutive sampling edges.
    task automatic ticks(input int n);
        @(negedge clk);
        tick = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        tick = 1'b0;
    endtask

    function automatic logic [15:0] to_bcd(input int s);
        int m, ss;
        m  = (s / 60) % 100;
        ss = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[12];
        vecs[0]  = '{1'b1, 1'b0, 16'h0001, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 16'h0001, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 16'h0002, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 16'h0000, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 16'h0000, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 16'h0001, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 16'h0002, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 16'h0002, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 16'h0003, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 16'h0000, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 16'h0001, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 16'h0001, 1'b0};

        // Reset state.
        #2;
        chk("rst time", w_time, 16'h0000);
        chk("rst disp", w_disp, 16'h0000);
        chk("rst flags", {w_mp, w_ovf, w_la}, 3'b000);
        chk("rst sat time", s_time, 16'h0000);
        @(negedge clk);
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        chk("no tick after rst", w_time, 16'h0000);

        // Table-driven basic counting and clear priority.
        for (int i = 0; i < 12; i++) begin
            step(vecs[i].t, vecs[i].c, 1'b0);
            chk($sformatf("vec%0d time", i), w_time, vecs[i].exp_time);
            chk($sformatf("vec%0d disp", i), w_disp, vecs[i].exp_time);
            chk($sformatf("vec%0d pulse", i), w_mp, vecs[i].exp_pulse);
            chk($sformatf("vec%0d ovf", i), w_ovf, 1'b0);
            chk($sformatf("vec%0d sat time", i), s_time, vecs[i].exp_time);
        end

        // 60 spaced ticks: exactly one minute strobe on the 60th update.
        step(1'b0, 1'b1, 1'b0);
        pulses = 0;
        for (int i = 1; i <= 60; i++) begin
            step(1'b1, 1'b0, 1'b0);
            chk($sformatf("cnt%0d time", i), w_time, to_bcd(i));
            chk($sformatf("cnt%0d pulse", i), w_mp, (i == 60));
            if (w_mp) pulses++;
            repeat (3) begin
                step(1'b0, 1'b0, 1'b0);
                if (w_mp) pulses++;
            end
        end
        chk("cnt pulse count", pulses, 1);
        chk("cnt final time", w_time, 16'h0100);
        chk("cnt ovf", w_ovf, 1'b0);

        // Preload to 99:59, then overflow in both wrap modes.
        step(1'b0, 1'b1, 1'b0);
        ticks(5999);
        chk("max wrap time", w_time, 16'h9959);
        chk("max sat time", s_time, 16'h9959);
        chk("max ovf", {w_ovf, s_ovf}, 2'b00);
        step(1'b1, 1'b0, 1'b0);
        chk("wrap time", w_time, 16'h0000);
        chk("wrap disp", w_disp, 16'h0000);
        chk("wrap ovf", w_ovf, 1'b1);
        chk("wrap pulse", w_mp, 1'b1);
        chk("sat time 1", s_time, 16'h9959);
        chk("sat ovf 1", s_ovf, 1'b1);
        chk("sat pulse 1", s_mp, 1'b0);
        for (int k = 2; k <= 3; k++) begin
            step(1'b1, 1'b0, 1'b0);
            chk($sformatf("post wrap time %0d", k), w_time, to_bcd(k - 1));
            chk($sformatf("post wrap ovf %0d", k), w_ovf, 1'b1);
            chk($sformatf("sat time %0d", k), s_time, 16'h9959);
            chk($sformatf("sat ovf %0d", k), s_ovf, 1'b1);
            chk($sformatf("sat pulse %0d", k), s_mp, 1'b0);
        end
        step(1'b0, 1'b1, 1'b0);
        chk("clear ovf", {w_ovf, s_ovf}, 2'b00);
        chk("clear disp", w_disp, 16'h0000);
        chk("clear sat time", s_time, 16'h0000);

        // Lap behaviour, then clear with tick at 00:42.
        ticks(7);
        chk("pre lap time", w_time, 16'h0007);
`ifdef STOPWATCH_LAP_EN
        step(1'b1, 1'b0, 1'b1);
        chk("lap disp", w_disp, 16'h0007);
        chk("lap active", w_la, 1'b1);
        chk("lap live", w_time, 16'h0008);
        ticks(5);
        chk("lap hold disp", w_disp, 16'h0007);
        chk("lap hold live", w_time, 16'h0013);
        step(1'b0, 1'b0, 1'b1);
        chk("lap2 disp", w_disp, 16'h0013);
        chk("lap2 active", w_la, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        chk("lap3 active", w_la, 1'b1);
        ticks(29);
        chk("lap3 live", w_time, 16'h0042);
        chk("lap3 disp", w_disp, 16'h0013);
        step(1'b1, 1'b1, 1'b0);
`else
        step(1'b1, 1'b0, 1'b1);
        chk("nolap disp", w_disp, 16'h0008);
        chk("nolap active", w_la, 1'b0);
        ticks(34);
        chk("nolap live", w_time, 16'h0042);
        chk("nolap disp2", w_disp, 16'h0042);
        step(1'b1, 1'b1, 1'b1);
`endif
        chk("clr tick time", w_time, 16'h0000);
        chk("clr tick disp", w_disp, 16'h0000);
        chk("clr tick active", w_la, 1'b0);

        // Async reset mid-count at 12:34 with overflow set.
        step(1'b0, 1'b1, 1'b0);
        ticks(6000);
        ticks(754);
        chk("pre rst time", w_time, 16'h1234);
        chk("pre rst ovf", w_ovf, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst time", w_time, 16'h0000);
        chk("arst disp", w_disp, 16'h0000);
        chk("arst flags", {w_mp, w_ovf, w_la}, 3'b000);
        chk("arst sat", {s_time, s_ovf}, 17'h0);
        @(negedge clk);
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        chk("post rst idle", w_time, 16'h0000);
        step(1'b1, 1'b0, 1'b0);
        chk("post rst tick", w_time, 16'h0001);
        chk("post rst ovf", w_ovf, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
